// File: rtl/imem_pkg.sv
// Shared types and constants for the byte-wide instruction memory port.
// Words are big-endian: byte 0 (lowest address) is bits [31:24].
package imem_pkg;

    localparam int DEF_ADDR_W     = 10;
    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int LANE_TOP       = 31;
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, WRITE} state_t;

    // Byte k of a word in big-endian order.
    function automatic logic [7:0] be_lane(input logic [31:0] w, input logic [1:0] k);
        return w[LANE_TOP - BYTE_W * int'(k) -: BYTE_W];
    endfunction

endpackage

// File: rtl/imem_byte_shifter.sv
// Left-shifting word assembler: each enable pushes one byte into the low lane,
// so four enables leave the first byte in the MSB.
module imem_byte_shifter (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [7:0]  din,
    output logic [31:0] word
);

    always_ff @(posedge clk) begin
        if (rst)
            word <= '0;
        else if (en)
            word <= {word[23:0], din};
    end

endmodule

// File: rtl/imem_port_ctrl.sv
// Arbitrates one byte-wide synchronous RAM between 32-bit fetch reads and
// 32-bit loader writes, sequencing each word as four big-endian byte accesses.
module imem_port_ctrl
    import imem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter bit LOAD_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic              fetch_valid,
    output logic [31:0]       fetch_inst,
    input  logic              load_valid,
    input  logic [31:0]       load_addr,
    input  logic [31:0]       load_data,
    output logic              load_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);

    state_t      state;
    logic [1:0]  k;
    logic        last_grant;   // 1 = loader was granted last
    logic [31:0] data_q;
    logic [31:0] shift_word;
    logic        shift_en;
    logic        unused;

    assign unused = ^{fetch_addr[31:ADDR_W], load_addr[31:ADDR_W], shift_word[31:24]};

    // RAM data lags the address by one cycle, so the first READ cycle has nothing to take.
    assign shift_en = (state == READ && k != 2'd0) || state == DRAIN;

    imem_byte_shifter u_shift (
        .clk  (clk),
        .rst  (rst),
        .en   (shift_en),
        .din  (mem_rdata),
        .word (shift_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= '0;
            last_grant  <= ~LOAD_FIRST;
            data_q      <= '0;
            fetch_valid <= 1'b0;
            fetch_inst  <= '0;
            load_ready  <= 1'b0;
            busy        <= 1'b0;
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
        end else begin
            fetch_valid <= 1'b0;
            load_ready  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_valid && !(fetch_req && last_grant)) begin
                        state      <= WRITE;
                        k          <= '0;
                        last_grant <= 1'b1;
                        data_q     <= load_data;
                        load_ready <= 1'b1;
                        busy       <= 1'b1;
                        mem_addr   <= load_addr[ADDR_W-1:0];
                        mem_we     <= 1'b1;
                        mem_wdata  <= be_lane(load_data, 2'd0);
                    end else if (fetch_req) begin
                        state      <= READ;
                        k          <= '0;
                        last_grant <= 1'b0;
                        busy       <= 1'b1;
                        mem_addr   <= fetch_addr[ADDR_W-1:0];
                    end
                end
                READ: begin
                    if (k == LAST_BYTE) begin
                        state <= DRAIN;
                    end else begin
                        k        <= k + 2'd1;
                        mem_addr <= mem_addr + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    fetch_valid <= 1'b1;
                    fetch_inst  <= {shift_word[23:0], mem_rdata};
                end
                WRITE: begin
                    if (k == LAST_BYTE) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        mem_we <= 1'b0;
                    end else begin
                        k         <= k + 2'd1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        mem_wdata <= be_lane(data_q, k + 2'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
